// File: rtl/pcm_decimator.sv
// Decimates the filter output by DECIM and buffers kept samples in a small FIFO with valid/ready output.
// Define PCM_DECIM_AVG_EN to replace sample picking with a boxcar pre-average over each window.
module pcm_decimator #(
   parameter int DATA_WIDTH = 16,
   parameter int DECIM      = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_WIDTH-1:0]         din,
   input  logic                          valid_in,
   output logic [DATA_WIDTH-1:0]         dout,
   output logic                          valid_out,
   input  logic                          ready_in,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fill
);

   localparam int PH_W   = $clog2(DECIM);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FILL_W = PTR_W + 1;

   logic [PH_W-1:0]       phase_q,    phase_d;
   logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
   logic [FILL_W-1:0]     fill_q,     fill_d;
   logic                  overflow_q, overflow_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];

   logic                  keep;
   logic [DATA_WIDTH-1:0] push_val;
   logic                  pop;
   logic                  full;
   logic                  push_ok;

`ifdef PCM_DECIM_AVG_EN
   localparam int ACC_W = DATA_WIDTH + PH_W;

   logic signed [ACC_W-1:0] acc_q, acc_d, sum;

   // The window closes on its last sample, so the push carries the full sum including din.
   always_comb begin
      sum      = acc_q + ACC_W'($signed(din));
      keep     = valid_in && (phase_q == PH_W'(DECIM - 1));
      push_val = DATA_WIDTH'(sum >>> PH_W);
      acc_d    = acc_q;
      if (valid_in) begin
         acc_d = keep ? '0 : sum;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
`else
   always_comb begin
      keep     = valid_in && (phase_q == '0);
      push_val = din;
   end
`endif

   always_comb begin
      pop        = (fill_q != '0) && ready_in;
      full       = (fill_q == FILL_W'(FIFO_DEPTH));
      // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
      push_ok    = keep && (!full || pop);

      phase_d    = valid_in ? phase_q + PH_W'(1) : phase_q;
      wr_ptr_d   = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      overflow_d = overflow_q || (keep && !push_ok);

      fill_d = fill_q;
      if (push_ok && !pop) begin
         fill_d = fill_q + FILL_W'(1);
      end else if (pop && !push_ok) begin
         fill_d = fill_q - FILL_W'(1);
      end

      // NOTE: blocking assignments here build combinational next-state; only the always_ff uses <=.
      mem_d = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         overflow_q <= 1'b0;
         // NOTE: the buffer is reset so dout, read straight from mem_q, comes out of reset as 0.
         mem_q      <= '{default: '0};
      end else begin
         phase_q    <= phase_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         overflow_q <= overflow_d;
         mem_q      <= mem_d;
      end
   end

   assign dout      = mem_q[rd_ptr_q];
   assign valid_out = (fill_q != '0);
   assign overflow  = overflow_q;
   assign fill      = fill_q;

endmodule

// File: tb/tb_pcm_decimator.sv
// Directed self-checking bench for pcm_decimator; pick-mode scenarios by default,
// boxcar-average scenario when PCM_DECIM_AVG_EN is defined (DECIM=4 then).
module tb_pcm_decimator;

`ifdef PCM_DECIM_AVG_EN
   localparam int DECIM_P = 4;
`else
   localparam int DECIM_P = 64;
`endif
   localparam int DW      = 16;
   localparam int DEPTH_P = 4;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] din;
   logic          valid_in;
   logic [DW-1:0] dout;
   logic          valid_out;
   logic          ready_in;
   logic          overflow;
   logic [2:0]    fill;

   int check_cnt = 0;
   int pass_cnt  = 0;

   pcm_decimator #(
      .DATA_WIDTH (DW),
      .DECIM      (DECIM_P),
      .FIFO_DEPTH (DEPTH_P)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .valid_in  (valid_in),
      .dout      (dout),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .overflow  (overflow),
      .fill      (fill)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n    = 1'b0;
      valid_in = 1'b0;
      ready_in = 1'b0;
      din      = '0;
      #3;
      step();
      step();
      #2 rst_n = 1'b1;
   endtask

   // Drives a ramp din=from..to with valid_in=1; ready_in left as the caller set it.
   task automatic feed(input int from, input int to);
      valid_in = 1'b1;
      for (int k = from; k <= to; k++) begin
         din = DW'(k);
         step();
      end
      valid_in = 1'b0;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      valid_in = 1'b0;
      ready_in = 1'b0;
      din      = '0;
      #1;
      check_cnt++;
      if (valid_out !== 1'b0 || dout !== '0 || fill !== '0 || overflow !== 1'b0)
         $display("FAIL reset_async got valid=%b dout=%h fill=%0d ovf=%b exp 0/0000/0/0",
                  valid_out, dout, fill, overflow);
      else pass_cnt++;
      step();
      #2 rst_n = 1'b1;
      step();
      check_cnt++;
      if (valid_out !== 1'b0 || dout !== '0 || fill !== '0 || overflow !== 1'b0)
         $display("FAIL reset_release got valid=%b dout=%h fill=%0d ovf=%b exp 0/0000/0/0",
                  valid_out, dout, fill, overflow);
      else pass_cnt++;
   endtask

`ifndef PCM_DECIM_AVG_EN
   task automatic test_ramp();
      apply_reset();
      ready_in = 1'b1;
      valid_in = 1'b1;
      for (int k = 0; k < 3 * DECIM_P; k++) begin
         din = DW'(k);
         step();
         check_cnt++;
         if (k % DECIM_P == 0) begin
            if (valid_out !== 1'b1 || dout !== DW'(k))
               $display("FAIL ramp_keep k=%0d got valid=%b dout=%0d exp valid=1 dout=%0d",
                        k, valid_out, dout, k);
            else pass_cnt++;
         end else begin
            if (valid_out !== 1'b0)
               $display("FAIL ramp_pulse k=%0d got valid=%b exp 0", k, valid_out);
            else pass_cnt++;
         end
      end
      valid_in = 1'b0;
   endtask

   task automatic test_gapped();
      apply_reset();
      ready_in = 1'b1;
      for (int c = 0; c < 6 * DECIM_P; c++) begin
         valid_in = (c % 2 == 0);
         din      = valid_in ? DW'(c / 2) : 16'h7777;
         step();
         check_cnt++;
         if (c % (2 * DECIM_P) == 0) begin
            if (valid_out !== 1'b1 || dout !== DW'(c / 2))
               $display("FAIL gapped_keep c=%0d got valid=%b dout=%0d exp valid=1 dout=%0d",
                        c, valid_out, dout, c / 2);
            else pass_cnt++;
         end else begin
            if (valid_out !== 1'b0)
               $display("FAIL gapped_pulse c=%0d got valid=%b exp 0", c, valid_out);
            else pass_cnt++;
         end
      end
      valid_in = 1'b0;
   endtask

   task automatic test_back_pressure();
      apply_reset();
      ready_in = 1'b0;
      feed(0, 3 * DECIM_P);
      check_cnt++;
      if (fill !== 3'd4 || overflow !== 1'b0 || dout !== '0)
         $display("FAIL bp_full got fill=%0d ovf=%b dout=%0d exp 4/0/0", fill, overflow, dout);
      else pass_cnt++;
      feed(3 * DECIM_P + 1, 4 * DECIM_P);
      check_cnt++;
      if (fill !== 3'd4 || overflow !== 1'b1)
         $display("FAIL bp_drop got fill=%0d ovf=%b exp 4/1", fill, overflow);
      else pass_cnt++;
      ready_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_cnt++;
         if (valid_out !== 1'b1 || dout !== DW'(i * DECIM_P))
            $display("FAIL bp_drain i=%0d got valid=%b dout=%0d exp valid=1 dout=%0d",
                     i, valid_out, dout, i * DECIM_P);
         else pass_cnt++;
         step();
      end
      check_cnt++;
      if (valid_out !== 1'b0 || fill !== '0 || overflow !== 1'b1)
         $display("FAIL bp_empty got valid=%b fill=%0d ovf=%b exp 0/0/1",
                  valid_out, fill, overflow);
      else pass_cnt++;
      ready_in = 1'b0;
   endtask

   task automatic test_full_push_pop();
      apply_reset();
      ready_in = 1'b0;
      feed(0, 3 * DECIM_P);
      valid_in = 1'b1;
      for (int k = 3 * DECIM_P + 1; k < 4 * DECIM_P; k++) begin
         din = DW'(k);
         step();
         check_cnt++;
         if (dout !== '0 || valid_out !== 1'b1)
            $display("FAIL hold_stable k=%0d got valid=%b dout=%0d exp valid=1 dout=0",
                     k, valid_out, dout);
         else pass_cnt++;
      end
      ready_in = 1'b1;
      din      = DW'(4 * DECIM_P);
      step();
      valid_in = 1'b0;
      check_cnt++;
      if (fill !== 3'd4 || overflow !== 1'b0 || dout !== DW'(DECIM_P))
         $display("FAIL full_pushpop got fill=%0d ovf=%b dout=%0d exp 4/0/%0d",
                  fill, overflow, dout, DECIM_P);
      else pass_cnt++;
      for (int i = 1; i <= 4; i++) begin
         check_cnt++;
         if (valid_out !== 1'b1 || dout !== DW'(i * DECIM_P))
            $display("FAIL full_drain i=%0d got valid=%b dout=%0d exp valid=1 dout=%0d",
                     i, valid_out, dout, i * DECIM_P);
         else pass_cnt++;
         step();
      end
      ready_in = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [DW-1:0] exp_val;
      exp_val = -16'sd1000;
      apply_reset();
      ready_in = 1'b0;
      feed(0, 4 * DECIM_P);
      ready_in = 1'b1;
      step();
      ready_in = 1'b0;
      check_cnt++;
      if (fill !== 3'd3 || overflow !== 1'b1)
         $display("FAIL arst_pre got fill=%0d ovf=%b exp 3/1", fill, overflow);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      check_cnt++;
      if (valid_out !== 1'b0 || fill !== '0 || overflow !== 1'b0 || dout !== '0)
         $display("FAIL arst_mid got valid=%b fill=%0d ovf=%b dout=%h exp 0/0/0/0000",
                  valid_out, fill, overflow, dout);
      else pass_cnt++;
      #1 rst_n = 1'b1;
      valid_in = 1'b1;
      din      = exp_val;
      step();
      valid_in = 1'b0;
      check_cnt++;
      if (valid_out !== 1'b1 || dout !== exp_val || fill !== 3'd1)
         $display("FAIL arst_first got valid=%b dout=%h fill=%0d exp 1/%h/1",
                  valid_out, dout, fill, exp_val);
      else pass_cnt++;
   endtask
`else
   task automatic test_average();
      int            vals [8] = '{3, 4, 5, -1, -1, -1, -1, -2};
      logic [DW-1:0] exp_val;
      apply_reset();
      ready_in = 1'b1;
      valid_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         din = DW'(vals[i]);
         step();
         check_cnt++;
         if (i % 4 != 3) begin
            if (valid_out !== 1'b0)
               $display("FAIL avg_idle i=%0d got valid=%b exp 0", i, valid_out);
            else pass_cnt++;
         end else begin
            exp_val = (i == 3) ? 16'sd2 : -16'sd2;
            if (valid_out !== 1'b1 || dout !== exp_val)
               $display("FAIL avg_push i=%0d got valid=%b dout=%h exp valid=1 dout=%h",
                        i, valid_out, dout, exp_val);
            else pass_cnt++;
         end
      end
      valid_in = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
`ifndef PCM_DECIM_AVG_EN
      test_ramp();
      test_gapped();
      test_back_pressure();
      test_full_push_pop();
      test_async_reset();
`else
      test_average();
`endif
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
